// File: rtl/piso_tx_arbiter.sv
// ---------------------------------------------------------------------------
// piso_tx_arbiter
//
// Shares one WIDTH-bit parallel-in/serial-out shift register between two
// requesters. A round-robin arbiter picks the next word. The FSM then
// sequences the PISO load and shift controls and counts out WIDTH bits, MSB
// first. It can also insert GAP idle cycles between frames.
//
// Parameters
//   WIDTH  word width, must match the PISO (>= 2)
//   GAP    idle cycles forced between frames (0 = back-to-back frames)
//   FILL   value driven on the PISO serial input while shifting
//
// Ports
//   in_clk, in_rst_n      clock (rising edge), asynchronous active-low reset
//   in_req0/1, in_data0/1 requests; hold req and data stable until the grant
//   o_gnt0/1              1-cycle pulse: that word is loaded at this edge
//   o_done0/1             1-cycle pulse on the last bit cycle of a frame
//   o_l, o_s, o_si        PISO parallel data, mode (0=load, 1=shift), serial-in
//   o_bit_valid           PISO o_q holds a frame bit this cycle
//   o_owner               requester owning the current frame
//   o_busy                high in LOAD, SHIFT and GAP
// ---------------------------------------------------------------------------
module piso_tx_arbiter #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned GAP   = 1,
   parameter logic        FILL  = 1'b0
) (
   input  logic             in_clk,
   input  logic             in_rst_n,
   input  logic             in_req0,
   input  logic [WIDTH-1:0] in_data0,
   input  logic             in_req1,
   input  logic [WIDTH-1:0] in_data1,
   output logic             o_gnt0,
   output logic             o_gnt1,
   output logic             o_done0,
   output logic             o_done1,
   output logic [WIDTH-1:0] o_l,
   output logic             o_s,
   output logic             o_si,
   output logic             o_bit_valid,
   output logic             o_owner,
   output logic             o_busy
);

   localparam int unsigned CNT_W = $clog2(WIDTH);
   localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_GAP   = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             owner_q, owner_d;
   logic             last_q, last_d;
   logic             any_req;
   logic             winner;
   logic             bit_last;
   logic             gap_last;
   logic             go_load;

   assign any_req  = in_req0 | in_req1;
   // Under contention the requester that did not win last time goes next.
   assign winner   = (in_req0 & in_req1) ? ~last_q : in_req1;
   assign bit_last = (cnt_q == CNT_W'(WIDTH - 1));

   // The gap counter only exists when gaps are configured. It clears on
   // its last cycle, so it never goes past GAP-1.
   generate
      if (GAP > 0) begin : g_gap
         logic [GAP_W-1:0] gap_q, gap_d;

         assign gap_last = (gap_q == GAP_W'(GAP - 1));

         always_comb begin
            gap_d = '0;
            if ((state_q == ST_GAP) && !gap_last) gap_d = gap_q + 1'b1;
         end

         always_ff @(posedge in_clk or negedge in_rst_n) begin
            if (!in_rst_n) gap_q <= '0;
            else           gap_q <= gap_d;
         end
      end else begin : g_no_gap
         assign gap_last = 1'b1;
      end
   endgenerate

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
      state_d = state_q;
      cnt_d   = '0;
      owner_d = owner_q;
      last_d  = last_q;
      go_load = 1'b0;

      case (state_q)
         ST_IDLE:  go_load = any_req;
         ST_LOAD:  state_d = ST_SHIFT;
         ST_SHIFT: begin
            if (!bit_last) begin
               cnt_d = cnt_q + 1'b1;
            end else if (GAP > 0) begin
               state_d = ST_GAP;
            end else begin
               go_load = any_req;
               if (!any_req) state_d = ST_IDLE;
            end
         end
         ST_GAP: begin
            if (gap_last) begin
               go_load = any_req;
               if (!any_req) state_d = ST_IDLE;
            end
         end
         default:  state_d = ST_IDLE;
      endcase

      // Arbitration happens only on the way into LOAD. The owner then stays
      // fixed for the whole frame, even if its request drops early.
      if (go_load) begin
         state_d = ST_LOAD;
         owner_d = winner;
         last_d  = winner;
      end
   end

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q <= state_d;
         cnt_q   <= cnt_d;
         owner_q <= owner_d;
         last_q  <= last_d;
      end
   end

   // All outputs decode from registered state. A mid-frame reset therefore
   // drops them at once and no done pulse is produced.
   assign o_busy      = (state_q != ST_IDLE);
   assign o_s         = (state_q == ST_SHIFT);
   assign o_bit_valid = (state_q == ST_SHIFT);
   assign o_si        = FILL;
   assign o_owner     = owner_q;
   assign o_l         = (state_q == ST_LOAD) ? (owner_q ? in_data1 : in_data0) : '0;
   assign o_gnt0      = (state_q == ST_LOAD) & ~owner_q;
   assign o_gnt1      = (state_q == ST_LOAD) &  owner_q;
   assign o_done0     = (state_q == ST_SHIFT) & bit_last & ~owner_q;
   assign o_done1     = (state_q == ST_SHIFT) & bit_last &  owner_q;

endmodule

// File: tb/tb_piso_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_piso_tx_arbiter
//
// Scoreboard bench for piso_tx_arbiter. The bench contains two DUTs. Each one
// drives a small behavioural PISO so the real serial stream can be observed:
//   dut_a  WIDTH=4, GAP=1  reset, single frame, contention, fairness,
//                          late request, mid-frame reset
//   dut_b  WIDTH=4, GAP=0  back-to-back frames
// Stimulus pushes the expected grants and bits into queues. Negedge monitors
// pop and compare whenever a DUT shows a grant or a valid bit.
// ---------------------------------------------------------------------------
module tb_piso_tx_arbiter;

   localparam int W = 4;

   typedef struct packed {
      logic owner;
      logic b;
      logic last;
   } bit_exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // DUT A signals
   logic         req0_a, req1_a;
   logic [W-1:0] data0_a, data1_a;
   logic         gnt0_a, gnt1_a, done0_a, done1_a, s_a, si_a, bv_a, own_a, busy_a;
   logic [W-1:0] l_a, pr_a;
   // DUT B signals
   logic         req0_b, req1_b;
   logic [W-1:0] data0_b, data1_b;
   logic         gnt0_b, gnt1_b, done0_b, done1_b, s_b, si_b, bv_b, own_b, busy_b;
   logic [W-1:0] l_b, pr_b;

   logic     gq_a[$], gq_b[$];
   bit_exp_t bq_a[$], bq_b[$];
   bit_exp_t eb_a, eb_b;
   logic     eg_a, eg_b;

   piso_tx_arbiter #(.WIDTH(W), .GAP(1), .FILL(1'b0)) dut_a (
      .in_clk(clk), .in_rst_n(rst_n),
      .in_req0(req0_a), .in_data0(data0_a), .in_req1(req1_a), .in_data1(data1_a),
      .o_gnt0(gnt0_a), .o_gnt1(gnt1_a), .o_done0(done0_a), .o_done1(done1_a),
      .o_l(l_a), .o_s(s_a), .o_si(si_a), .o_bit_valid(bv_a),
      .o_owner(own_a), .o_busy(busy_a)
   );

   piso_tx_arbiter #(.WIDTH(W), .GAP(0), .FILL(1'b0)) dut_b (
      .in_clk(clk), .in_rst_n(rst_n),
      .in_req0(req0_b), .in_data0(data0_b), .in_req1(req1_b), .in_data1(data1_b),
      .o_gnt0(gnt0_b), .o_gnt1(gnt1_b), .o_done0(done0_b), .o_done1(done1_b),
      .o_l(l_b), .o_s(s_b), .o_si(si_b), .o_bit_valid(bv_b),
      .o_owner(own_b), .o_busy(busy_b)
   );

   // Behavioural PISOs: in_s=0 loads in_l, in_s=1 shifts left taking in_si.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) pr_a <= '0;
      else        pr_a <= s_a ? {pr_a[W-2:0], si_a} : l_a;
   end
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) pr_b <= '0;
      else        pr_b <= s_b ? {pr_b[W-2:0], si_b} : l_b;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_frame_a(input logic o, input logic [W-1:0] d);
      gq_a.push_back(o);
      for (int i = W - 1; i >= 0; i--) bq_a.push_back(bit_exp_t'{o, d[i], (i == 0)});
   endtask

   task automatic push_frame_b(input logic o, input logic [W-1:0] d);
      gq_b.push_back(o);
      for (int i = W - 1; i >= 0; i--) bq_b.push_back(bit_exp_t'{o, d[i], (i == 0)});
   endtask

   // Monitor for DUT A
   always @(negedge clk) begin
      if (gnt0_a || gnt1_a) begin
         if (gq_a.size() == 0) check("a_gnt_unexpected", 32'({gnt1_a, gnt0_a}), 32'd0);
         else begin
            eg_a = gq_a.pop_front();
            check("a_gnt", 32'({gnt1_a, gnt0_a}), eg_a ? 32'd2 : 32'd1);
         end
      end
      if (bv_a) begin
         if (bq_a.size() == 0) check("a_bit_unexpected", 32'(bv_a), 32'd0);
         else begin
            eb_a = bq_a.pop_front();
            check("a_bit", 32'(pr_a[W-1]), 32'(eb_a.b));
            check("a_owner", 32'(own_a), 32'(eb_a.owner));
            check("a_done", 32'({done1_a, done0_a}),
                  eb_a.last ? (eb_a.owner ? 32'd2 : 32'd1) : 32'd0);
         end
      end else if (done0_a || done1_a) begin
         check("a_done_stray", 32'({done1_a, done0_a}), 32'd0);
      end
   end

   // Monitor for DUT B
   always @(negedge clk) begin
      if (gnt0_b || gnt1_b) begin
         if (gq_b.size() == 0) check("b_gnt_unexpected", 32'({gnt1_b, gnt0_b}), 32'd0);
         else begin
            eg_b = gq_b.pop_front();
            check("b_gnt", 32'({gnt1_b, gnt0_b}), eg_b ? 32'd2 : 32'd1);
         end
      end
      if (bv_b) begin
         if (bq_b.size() == 0) check("b_bit_unexpected", 32'(bv_b), 32'd0);
         else begin
            eb_b = bq_b.pop_front();
            check("b_bit", 32'(pr_b[W-1]), 32'(eb_b.b));
            check("b_owner", 32'(own_b), 32'(eb_b.owner));
            check("b_done", 32'({done1_b, done0_b}),
                  eb_b.last ? (eb_b.owner ? 32'd2 : 32'd1) : 32'd0);
         end
      end else if (done0_b || done1_b) begin
         check("b_done_stray", 32'({done1_b, done0_b}), 32'd0);
      end
   end

   // Polls for a grant from DUT A, bounded. Returns with the clock sitting
   // 1 time unit after the edge that entered LOAD.
   task automatic wait_gnt_a(input logic r, output int t);
      logic hit = 1'b0;
      for (int k = 0; k < 40 && !hit; k++) begin
         @(posedge clk); #1;
         hit = r ? gnt1_a : gnt0_a;
      end
      t = cyc;
      check(r ? "a_wait_gnt1" : "a_wait_gnt0", 32'(hit), 32'd1);
   endtask

   task automatic wait_gnt_b(output int t);
      logic hit = 1'b0;
      for (int k = 0; k < 40 && !hit; k++) begin
         @(posedge clk); #1;
         hit = gnt1_b;
      end
      t = cyc;
      check("b_wait_gnt1", 32'(hit), 32'd1);
   endtask

   task automatic drain();
      int k = 0;
      while ((gq_a.size() + bq_a.size() + gq_b.size() + bq_b.size()) != 0 && k < 60) begin
         @(posedge clk);
         k++;
      end
      check("drain_queues", 32'(gq_a.size() + bq_a.size() + gq_b.size() + bq_b.size()), 32'd0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, t1, tp, t_rel;

      rst_n   = 1'b0;
      req0_a  = 1'b1; req1_a = 1'b0; data0_a = 4'b1101; data1_a = '0;
      req0_b  = 1'b0; req1_b = 1'b0; data0_b = '0;      data1_b = '0;

      // Reset with req0 held high. Outputs must stay quiet, then one frame of 1101 follows.
      push_frame_a(1'b0, 4'b1101);
      repeat (2) begin
         @(negedge clk);
         check("rst_outputs_a", 32'({gnt0_a, gnt1_a, done0_a, done1_a, l_a, s_a,
                                     bv_a, own_a, busy_a, si_a}), 32'd0);
         check("rst_outputs_b", 32'({gnt0_b, gnt1_b, busy_b, bv_b, s_b, own_b}), 32'd0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      t_rel = cyc;
      @(negedge clk);
      check("no_gnt_at_release", 32'({gnt1_a, gnt0_a}), 32'd0);
      wait_gnt_a(1'b0, t0);
      check("gnt_latency", 32'(t0 - t_rel), 32'd1);
      @(posedge clk); #1;
      req0_a = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("gap_cycle", 32'({busy_a, s_a, bv_a}), 32'b100);
      @(posedge clk); #1;
      check("idle_after_gap", 32'(busy_a), 32'd0);
      drain();

      // Contention from reset: req0 wins first, req1 gets the next LOAD.
      rst_n  = 1'b0;
      req0_a = 1'b1; req1_a = 1'b1; data0_a = 4'hA; data1_a = 4'h5;
      push_frame_a(1'b0, 4'hA);
      push_frame_a(1'b1, 4'h5);
      @(posedge clk); #1;
      rst_n = 1'b1;
      wait_gnt_a(1'b0, t0);
      @(posedge clk); #1;
      req0_a = 1'b0;
      wait_gnt_a(1'b1, t1);
      check("contend_period", 32'(t1 - t0), 32'd6);
      @(posedge clk); #1;
      req1_a = 1'b0;
      drain();

      // Fairness: both held for four frames. Order is 0,1,0,1 with a 6-cycle period.
      req0_a = 1'b1; req1_a = 1'b1; data0_a = 4'h3; data1_a = 4'hC;
      push_frame_a(1'b0, 4'h3);
      push_frame_a(1'b1, 4'hC);
      push_frame_a(1'b0, 4'h3);
      push_frame_a(1'b1, 4'hC);
      tp = 0;
      for (int i = 0; i < 4; i++) begin
         wait_gnt_a(logic'(i % 2), t0);
         if (i > 0) check("fair_period", 32'(t0 - tp), 32'd6);
         tp = t0;
         if (i >= 2) begin
            @(posedge clk); #1;
            if (i == 2) req0_a = 1'b0;
            else        req1_a = 1'b0;
         end
      end
      drain();

      // A request that arrives during SHIFT is held and served at the next LOAD.
      req0_a = 1'b1; data0_a = 4'h9;
      push_frame_a(1'b0, 4'h9);
      push_frame_a(1'b1, 4'h6);
      wait_gnt_a(1'b0, t0);
      @(posedge clk); #1;
      req0_a = 1'b0;
      @(posedge clk); #1;
      req1_a = 1'b1; data1_a = 4'h6;
      wait_gnt_a(1'b1, t1);
      check("late_req_period", 32'(t1 - t0), 32'd6);
      @(posedge clk); #1;
      req1_a = 1'b0;
      drain();

      // Back-to-back frames with GAP=0: the second grant follows the last bit directly.
      req1_b = 1'b1; data1_b = 4'hB;
      push_frame_b(1'b1, 4'hB);
      push_frame_b(1'b1, 4'h2);
      wait_gnt_b(t0);
      @(posedge clk); #1;
      data1_b = 4'h2;
      wait_gnt_b(t1);
      check("b2b_period", 32'(t1 - t0), 32'd5);
      @(posedge clk); #1;
      req1_b = 1'b0;
      drain();

      // Mid-frame reset on the 2nd SHIFT cycle. Only the first bit is seen,
      // no done pulse appears, and a clean frame follows the release.
      req0_a = 1'b1; data0_a = 4'hE;
      gq_a.push_back(1'b0);
      bq_a.push_back(bit_exp_t'{1'b0, 1'b1, 1'b0});
      wait_gnt_a(1'b0, t0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("midrst_async", 32'({s_a, bv_a, busy_a, own_a, done0_a, done1_a, l_a}), 32'd0);
      repeat (2) begin
         @(negedge clk);
         check("midrst_held", 32'({bv_a, done0_a, done1_a, gnt0_a}), 32'd0);
      end
      push_frame_a(1'b0, 4'hE);
      @(posedge clk); #1;
      rst_n = 1'b1;
      t_rel = cyc;
      wait_gnt_a(1'b0, t0);
      check("midrst_latency", 32'(t0 - t_rel), 32'd1);
      @(posedge clk); #1;
      req0_a = 1'b0;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
